// File: rtl/pll_lock_sequencer.sv
// PLL lock supervisor on the reference clock. It pulses the PLL reset, qualifies lock,
// and releases the downstream reset. Failed attempts are retried, and loss of lock
// starts the sequence again.
module pll_lock_sequencer #(
    parameter int RESET_PULSE  = 27,
    parameter int LOCK_TIMEOUT = 27000,
    parameter int LOCK_STABLE  = 2700,
    parameter int MAX_RETRIES  = 7
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       lock,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       ready,
    output logic       fail,
    output logic [7:0] relock_count
);

    localparam int MAX_AB = (RESET_PULSE > LOCK_TIMEOUT) ? RESET_PULSE : LOCK_TIMEOUT;
    localparam int MAX_T  = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
    localparam int TW     = $clog2(MAX_T + 1);

    localparam logic [TW-1:0] PULSE_END  = TW'(RESET_PULSE - 1);
    localparam logic [TW-1:0] WAIT_END   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_END = TW'(LOCK_STABLE - 1);
    localparam logic [7:0]    RETRY_MAX  = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    typedef struct packed {
        logic pll_reset;
        logic sys_reset;
        logic ready;
        logic fail;
    } outs_t;

    state_t          state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic [7:0]      retry, retry_n;
    logic [7:0]      relock_n;
    logic [1:0]      lock_pipe;
    logic            lock_s;
    logic            attempt_fail;
    outs_t           outs_n;

    assign lock_s = lock_pipe[1];

    always_comb begin
        state_n      = state;
        timer_n      = timer + TW'(1);
        retry_n      = retry;
        relock_n     = relock_count;
        attempt_fail = 1'b0;

        unique case (state)
            S_RESET: begin
                if (timer == PULSE_END)
                    state_n = S_WAIT;
            end
            S_WAIT: begin
                if (lock_s)
                    state_n = S_STABLE;
                else if (timer == WAIT_END)
                    attempt_fail = 1'b1;
            end
            S_STABLE: begin
                // A drop here restarts the full attempt, not just the stability timer
                if (!lock_s) begin
                    attempt_fail = 1'b1;
                end else if (timer == STABLE_END) begin
                    state_n = S_RUN;
                    retry_n = 8'd0;
                end
            end
            S_RUN: begin
                timer_n = '0;
                if (!lock_s) begin
                    state_n = S_RESET;
                    if (relock_count != 8'hFF)
                        relock_n = relock_count + 8'd1;
                end
            end
            S_FAIL: begin
                timer_n = '0;
            end
            default: begin
                state_n = S_RESET;
            end
        endcase

        if (attempt_fail) begin
            if (retry == RETRY_MAX) begin
                state_n = S_FAIL;
            end else begin
                retry_n = retry + 8'd1;
                state_n = S_RESET;
            end
        end

        if (state_n != state)
            timer_n = '0;

        // Outputs are decoded from the next state so they change on the transition edge
        outs_n = '{pll_reset: 1'b1, sys_reset: 1'b1, ready: 1'b0, fail: 1'b0};
        unique case (state_n)
            S_WAIT, S_STABLE: outs_n = '{pll_reset: 1'b0, sys_reset: 1'b1, ready: 1'b0, fail: 1'b0};
            S_RUN:            outs_n = '{pll_reset: 1'b0, sys_reset: 1'b0, ready: 1'b1, fail: 1'b0};
            S_FAIL:           outs_n = '{pll_reset: 1'b1, sys_reset: 1'b1, ready: 1'b0, fail: 1'b1};
            default:          outs_n = '{pll_reset: 1'b1, sys_reset: 1'b1, ready: 1'b0, fail: 1'b0};
        endcase
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            lock_pipe    <= 2'b00;
            state        <= S_RESET;
            timer        <= '0;
            retry        <= 8'd0;
            relock_count <= 8'd0;
            pll_reset    <= 1'b1;
            sys_reset    <= 1'b1;
            ready        <= 1'b0;
            fail         <= 1'b0;
        end else begin
            lock_pipe    <= {lock_pipe[0], lock};
            state        <= state_n;
            timer        <= timer_n;
            retry        <= retry_n;
            relock_count <= relock_n;
            pll_reset    <= outs_n.pll_reset;
            sys_reset    <= outs_n.sys_reset;
            ready        <= outs_n.ready;
            fail         <= outs_n.fail;
        end
    end

endmodule
